sqrt_poly_recon: RTL and testbench

//  Downstream neighbour of the sqrt range-reduction stage in the Box-Muller AWGN datapath.

---
 rtl/awgn_pkg.sv | 76 +++++++
 rtl/sqrt_coef_rom.sv | 36 +++
 rtl/sqrt_poly_recon.sv | 176 +++++++++++++++++
 tb/tb_sqrt_poly_recon.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/awgn_pkg.sv
// Shared types, widths and fixed-point formats for the Box-Muller sqrt datapath.
// Latency: none (declarations and elaboration-time helper functions only).
// Backpressure: not applicable.
package awgn_pkg;

    localparam int IN_W     = 21;  // f_temp, UQ2.19
    localparam int SEG_BITS = 5;   // segment index = x[IN_W-1 -: SEG_BITS]
    localparam int COEF_W   = 18;  // c1 UQ0.18, c0 UQ2.16
    localparam int OUT_W    = 17;  // f_out, UQ4.13
    localparam int EXP_W    = 6;   // signed exponent

    // Fractional bit counts of each fixed-point format
    localparam int X_FRAC   = 19;  // UQ2.19
    localparam int C1_FRAC  = 18;  // UQ0.18
    localparam int C0_FRAC  = 16;  // UQ2.16
    localparam int Y_FRAC   = 16;  // UQ2.16
    localparam int OUT_FRAC = 13;  // UQ4.13

    localparam int P_W       = COEF_W + IN_W;             // c1*x full product, UQ2.37
    localparam int P_TRUNC   = C1_FRAC + X_FRAC - Y_FRAC; // drop to UQ2.16
    localparam int Y_W       = COEF_W + 1;                // p + c0 with carry room
    localparam int SHIFT_W   = 36;                        // y << 15 fits with margin
    localparam int SAT_BIT   = 4 + Y_FRAC;                // 16.0 in the shifted UQ.16 value
    localparam int ALIGN     = Y_FRAC - OUT_FRAC;         // UQ.16 -> UQ.13
    localparam int ROM_DEPTH = 1 << SEG_BITS;

    typedef logic signed [EXP_W-1:0] exp_t;
    typedef logic [IN_W-1:0]         x_t;
    typedef logic [COEF_W-1:0]       coef_t;
    typedef logic [OUT_W-1:0]        out_t;

    typedef struct packed {
        coef_t c1;
        coef_t c0;
    } coef_pair_t;

    // Bitwise integer square root, floor(sqrt(n)); used only at elaboration
    function automatic logic [63:0] isqrt(input logic [63:0] n);
        logic [63:0] res;
        logic [63:0] trial;
        res = '0;
        for (int i = 31; i >= 0; i--) begin
            trial = res | (64'd1 << i);
            if (trial * trial <= n) res = trial;
        end
        return res;
    endfunction

    // floor(sqrt(k/8) * 2^20): segment k starts at x = k/8
    function automatic logic [63:0] seg_root(input int k);
        return isqrt(64'(k) << 37);
    endfunction

    // Chord through both segment end points. c0 is chosen so that the
    // truncated product plus c0 lands on round(sqrt(x0)*2^16) exactly at
    // the segment start, which makes x = 1.0 reconstruct to exactly 1.0.
    // Segments 0..7 (x < 1) are not valid inputs and hold zeros.
    function automatic coef_pair_t seg_coef(input int k);
        logic [63:0] r0;
        logic [63:0] r1;
        logic [63:0] c1;
        logic [63:0] c0;
        coef_pair_t  cp;
        cp = '0;
        if (k >= 8) begin
            r0    = seg_root(k);
            r1    = seg_root(k + 1);
            c1    = (r1 - r0) << 1;
            c0    = ((r0 + 64'd8) >> 4) - ((c1 * 64'(k)) >> 5);
            cp.c1 = c1[COEF_W-1:0];
            cp.c0 = c0[COEF_W-1:0];
        end
        return cp;
    endfunction

endpackage

// File: rtl/sqrt_coef_rom.sv
// Synchronous 2^SEG_BITS x {c1,c0} coefficient table for piecewise-linear sqrt.
// Latency: 1 cycle from addr to rd_dat.
// Backpressure: output register holds its value while en is low.
module sqrt_coef_rom
    import awgn_pkg::*;
(
    input  logic                clk,
    input  logic                en,
    input  logic [SEG_BITS-1:0] addr,
    output coef_pair_t          rd_dat
);

    coef_pair_t rom [ROM_DEPTH];
    coef_pair_t rd_d;
    coef_pair_t rd_q;

    // Table contents are fixed at elaboration from the chord fit
    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam coef_pair_t SEG_C = seg_coef(k);
        assign rom[k] = SEG_C;
    end

    // Read port advances only with the pipeline
    always_comb begin
        rd_d = rd_q;
        if (en) rd_d = rom[addr];
    end

    // Registered read data
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
    end

    assign rd_dat = rd_q;

endmodule

// File: rtl/sqrt_poly_recon.sv
// Piecewise-linear sqrt of x in [1,4) and rescale by 2^(exp/2); optional sat counter via SQRT_SAT_CNT_EN.
// Latency: 4 cycles, throughput 1 beat per cycle.
// Backpressure: en = !out_valid | out_ready stalls every stage at once; in_ready = en.
module sqrt_poly_recon
    import awgn_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         f_temp,
    input  logic signed [EXP_W-1:0] exp_f,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        f_out,
    output logic                    f_sat
`ifdef SQRT_SAT_CNT_EN
    ,
    output logic [15:0]             sat_cnt
`endif
);

    logic                en;
    logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                out_valid_q, out_valid_d;
    x_t                  x1_q, x1_d, x2_q, x2_d;
    exp_t                e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
    logic [SEG_BITS-1:0] seg1_q, seg1_d;
    coef_pair_t          coef2;
    coef_t               p3_q, p3_d, c0_3_q, c0_3_d;
    logic                bad3_q, bad3_d;
    out_t                f_out_q, f_out_d;
    logic                f_sat_q, f_sat_d;
    logic [Y_W-1:0]      y;
    exp_t                s;
    logic [EXP_W-1:0]    sh;
    logic [SHIFT_W-1:0]  y_shl;
    logic [SHIFT_W-1:0]  y_shr;

    // One global enable: a stalled output freezes the whole pipe
    always_comb begin
        en       = !out_valid_q || out_ready;
        in_ready = en;
    end

    // S1/S2 capture and valid propagation, all gated by en
    always_comb begin
        v1_d   = v1_q;
        x1_d   = x1_q;
        e1_d   = e1_q;
        seg1_d = seg1_q;
        v2_d   = v2_q;
        x2_d   = x2_q;
        e2_d   = e2_q;
        v3_d   = v3_q;
        e3_d   = e3_q;
        if (en) begin
            v1_d   = in_valid;
            x1_d   = f_temp;
            e1_d   = exp_f;
            seg1_d = f_temp[IN_W-1 -: SEG_BITS];
            v2_d   = v1_q;
            x2_d   = x1_q;
            e2_d   = e1_q;
            v3_d   = v2_q;
            e3_d   = e2_q;
        end
    end

    // S2 coefficient lookup, aligned with x2/e2
    sqrt_coef_rom u_rom (
        .clk    (clk),
        .en     (en),
        .addr   (seg1_q),
        .rd_dat (coef2)
    );

    // S3: c1*x in UQ2.37, truncated to UQ2.16; flag x < 1 inputs
    always_comb begin
        p3_d   = p3_q;
        c0_3_d = c0_3_q;
        bad3_d = bad3_q;
        if (en) begin
            p3_d   = COEF_W'((P_W'(coef2.c1) * P_W'(x2_q)) >> P_TRUNC);
            c0_3_d = coef2.c0;
            bad3_d = (x2_q[IN_W-1 -: 2] == 2'b00);
        end
    end

    // S4: y = p + c0, scale by 2^(exp>>>1), clamp at 16.0, realign to UQ4.13.
    // The most negative exponent gives a 16-bit right shift, which already
    // truncates y (at most 2.0) to zero after realignment.
    always_comb begin
        y       = Y_W'(p3_q) + Y_W'(c0_3_q);
        s       = e3_q >>> 1;
        sh      = s[EXP_W-1] ? EXP_W'(-s) : EXP_W'(s);
        y_shl   = SHIFT_W'(y) << sh;
        y_shr   = SHIFT_W'(y) >> sh;
        f_out_d = f_out_q;
        f_sat_d = f_sat_q;
        if (en) begin
            if (bad3_q) begin
                f_out_d = '0;
                f_sat_d = 1'b0;
            end else if (!s[EXP_W-1]) begin
                if (|(y_shl >> SAT_BIT)) begin
                    f_out_d = '1;
                    f_sat_d = 1'b1;
                end else begin
                    f_out_d = OUT_W'(y_shl >> ALIGN);
                    f_sat_d = 1'b0;
                end
            end else begin
                f_out_d = OUT_W'(y_shr >> ALIGN);
                f_sat_d = 1'b0;
            end
        end
        out_valid_d = en ? v3_q : out_valid_q;
    end

    // Control and output registers: reset drops every in-flight beat
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            f_out_q     <= '0;
            f_sat_q     <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            out_valid_q <= out_valid_d;
            f_out_q     <= f_out_d;
            f_sat_q     <= f_sat_d;
        end
    end

    // Datapath registers need no reset; their valid bits qualify them
    always_ff @(posedge clk) begin
        x1_q   <= x1_d;
        e1_q   <= e1_d;
        seg1_q <= seg1_d;
        x2_q   <= x2_d;
        e2_q   <= e2_d;
        e3_q   <= e3_d;
        p3_q   <= p3_d;
        c0_3_q <= c0_3_d;
        bad3_q <= bad3_d;
    end

    assign out_valid = out_valid_q;
    assign f_out     = f_out_q;
    assign f_sat     = f_sat_q;

`ifdef SQRT_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Count clamped beats as they leave; stick at all ones
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (out_valid_q && out_ready && f_sat_q && (sat_cnt_q != 16'hFFFF))
            sat_cnt_d = sat_cnt_q + 16'd1;
    end

    // Saturation counter register
    always_ff @(posedge clk) begin
        if (reset) sat_cnt_q <= '0;
        else       sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sqrt_poly_recon.sv
// Directed and streamed stimulus for sqrt_poly_recon with a queue scoreboard.
// Latency: checks the 4-cycle first-result timing and 1 beat/cycle streaming.
// Backpressure: stalls out_ready mid-stream and pulses reset with beats in flight.
module tb_sqrt_poly_recon;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] f_temp;
    logic signed [5:0] exp_f;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] f_out;
    logic        f_sat;
`ifdef SQRT_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int out_cnt  = 0;
    int exp_sat_cnt = 0;
    logic [17:0] sb [$];

    sqrt_poly_recon dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_temp    (f_temp),
        .exp_f     (exp_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out),
        .f_sat     (f_sat)
`ifdef SQRT_SAT_CNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // floor(sqrt(k/8) * 2^20) from real arithmetic
    function automatic longint root20(input int k);
        return longint'($floor($sqrt(real'(k) * 137438953472.0)));
    endfunction

    // Golden result {f_sat, f_out}: chord coefficients re-derived with reals,
    // then the UQ arithmetic of the datapath.
    function automatic logic [17:0] model(input logic [20:0] x, input logic signed [5:0] e);
        int     k;
        int     s;
        longint c1, c0, p, y, v;
        if (x[20:19] == 2'b00) return 18'h0;
        k  = int'(x[20:16]);
        c1 = 2 * (root20(k + 1) - root20(k));
        c0 = longint'($rtoi($sqrt(k / 8.0) * 65536.0 + 0.5)) - ((c1 * k) >>> 5);
        p  = (c1 * longint'(x)) >>> 21;
        y  = p + c0;
        s  = int'(e) >>> 1;
        if (s >= 0) begin
            v = y << s;
            if (v >= (longint'(1) << 20)) return {1'b1, 17'h1FFFF};
            return {1'b0, 17'(v >>> 3)};
        end
        return {1'b0, 17'((y >>> (-s)) >>> 3)};
    endfunction

    // Scoreboard: push accepted inputs, pop and compare transferred outputs
    always @(negedge clk) begin
        logic [17:0] e;
        if (!reset && out_valid && out_ready) begin
            out_cnt++;
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=output expected=none_pending");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_f_out", f_out, e[16:0]);
                chk("sb_f_sat", f_sat, e[17]);
                if (e[17] && exp_sat_cnt < 65535) exp_sat_cnt++;
            end
        end
        if (!reset && in_valid && in_ready) sb.push_back(model(f_temp, exp_f));
    end

    // Hold one beat on the input until accepted (bounded)
    task automatic send(input logic [20:0] x, input logic signed [5:0] e);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        f_temp   = x;
        exp_f    = e;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("send_accept", (guard < 100), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Single beat into an empty pipe; observe output timing and value
    task automatic lat_run(input logic [20:0] x, input logic signed [5:0] e,
                           output logic early_vld, output logic vld,
                           output logic [16:0] fo, output logic fs);
        send(x, e);
        repeat (2) @(posedge clk);
        #1;
        early_vld = out_valid;
        @(posedge clk);
        #1;
        vld = out_valid;
        fo  = f_out;
        fs  = f_sat;
    endtask

    logic [20:0] sx [20];
    logic [5:0]  se [20];

    initial begin
        logic        ev, v, fs;
        logic [16:0] fo;
        int          idx, cyc, n0;
        longint      d;

        reset     = 1'b1;
        in_valid  = 1'b0;
        f_temp    = '0;
        exp_f     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_f_out", f_out, 0);
        chk("rst_f_sat", f_sat, 0);
`ifdef SQRT_SAT_CNT_EN
        chk("rst_sat_cnt", sat_cnt, 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // x = 1.0, exp 0 -> 1.0
        lat_run(21'h080000, 6'sd0, ev, v, fo, fs);
        chk("one_early_vld", ev, 0);
        chk("one_vld", v, 1);
        chk("one_f_out", fo, 17'h02000);
        chk("one_f_sat", fs, 0);

        // x just under 4.0 -> about 2.0
        lat_run(21'h1FFFFF, 6'sd0, ev, v, fo, fs);
        d = longint'(fo) - 64'h4000;
        chk("four_tol", (d >= -2 && d <= 2), 1);

        // positive exponents: 8.0 and clamp at 16.0
        lat_run(21'h080000, 6'sd6, ev, v, fo, fs);
        chk("exp6_f_out", fo, 17'h10000);
        chk("exp6_f_sat", fs, 0);
        lat_run(21'h080000, 6'sd8, ev, v, fo, fs);
        chk("exp8_f_out", fo, 17'h1FFFF);
        chk("exp8_f_sat", fs, 1);

        // negative exponents: 0.25 and full underflow at the minimum exponent
        lat_run(21'h080000, -6'sd4, ev, v, fo, fs);
        chk("expm4_f_out", fo, 17'h00800);
        lat_run(21'h080000, -6'sd32, ev, v, fo, fs);
        chk("expm32_f_out", fo, 17'h00000);

        // illegal x < 1 gives zero, no clamp, and still produces a beat
        lat_run(21'h07FFFF, 6'sd8, ev, v, fo, fs);
        chk("bad_vld", v, 1);
        chk("bad_f_out", fo, 0);
        chk("bad_f_sat", fs, 0);
        @(posedge clk);
        #1;

        // 20-beat stream with out_ready low for 3 cycles in the middle
        for (int i = 0; i < 20; i++) begin
            sx[i] = 21'h080000 + 21'($urandom_range(0, 21'h17FFFF));
            se[i] = 6'($urandom_range(0, 63));
        end
        sx[5] = 21'h045678;
        sx[9] = 21'h080000;
        se[9] = 6'd8;
        idx = 0;
        cyc = 0;
        n0  = out_cnt;
        while (idx < 20 && cyc < 200) begin
            out_ready = !(cyc >= 10 && cyc < 13);
            in_valid  = 1'b1;
            f_temp    = sx[idx];
            exp_f     = se[idx];
            @(negedge clk);
            if (cyc == 10) begin
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
            end
            if (in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_cycles", cyc, 23);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("stream_drained", sb.size(), 0);
        chk("stream_count", out_cnt - n0, 20);
`ifdef SQRT_SAT_CNT_EN
        @(posedge clk);
        #1;
        chk("sat_cnt_value", sat_cnt, exp_sat_cnt);
`endif

        // reset with three beats in flight and a stalled output
        out_ready = 1'b0;
        n0 = out_cnt;
        send(21'h080000, 6'sd8);
        send(21'h0C0000, 6'sd2);
        send(21'h100000, -6'sd2);
        @(posedge clk);
        #1;
        chk("pre_rst_vld", out_valid, 1);
        reset = 1'b1;
        sb.delete();
        exp_sat_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_f_out", f_out, 0);
        chk("mid_rst_f_sat", f_sat, 0);
`ifdef SQRT_SAT_CNT_EN
        chk("mid_rst_sat_cnt", sat_cnt, 0);
`endif
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_vld", out_valid, 0);
        chk("post_rst_count", out_cnt - n0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
